test_sequencer: RTL and testbench
=================================

TEST_SEQUENCER -- requirements
Module: test_sequencer

Interface
REQ-001 Parameter N_TESTS, default 3; number of test stations sequenced per session, range 1..8.
REQ-002 Parameter GAP_MS, default 1000; idle milliseconds between tests, range 1..4095.
REQ-003 Parameter TIMEOUT_MS, default 5000; maximum milliseconds a test stays enabled, range 1..8191.
REQ-004 clk50M  input  1  system clock, all logic on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 tick_1k  input  1  one-cycle 1 ms strobe, synchronous to clk50M.
REQ-007 start  input  1  session start request, level; acted on at its rising edge.
REQ-008 abort  input  1  synchronous abort, level.
REQ-009 pass  input  N_TESTS  per-station success flag; bit i is honoured only while station i is enabled.
REQ-010 on  output  N_TESTS  one-hot station enable.
REQ-011 w  output  1  one-cycle arm pulse to the enabled station.
REQ-012 round  output  3  index of the current or last station.
REQ-013 score  output  4  count of passed stations this session.
REQ-014 best_ms  output  13  smallest reaction time in ms this session; 8191 means none.
REQ-015 busy  output  1  high in GAP, RUN and SCORE.
REQ-016 all_done  output  1  high in DONE.

Function
REQ-017 FSM states SHALL be IDLE, GAP, RUN, SCORE and DONE; state and all outputs registered.
REQ-018 start_rise SHALL be defined as start high this cycle and low the previous cycle, using a registered copy of start.
REQ-019 IDLE or DONE with start_rise SHALL go to GAP and clear round, score, ms_cnt and hit, and set best_ms to 8191.
REQ-020 GAP SHALL increment ms_cnt on each tick_1k; on the tick where ms_cnt reaches GAP_MS-1, go to RUN and clear ms_cnt.
REQ-021 On RUN entry: on[round] SHALL be 1 in the first RUN cycle, and w SHALL be 1 for exactly that cycle.
REQ-022 RUN SHALL increment ms_cnt per tick_1k; ms_cnt saturates at 8191.
REQ-023 RUN with pass[round]=1 SHALL go to SCORE with hit=1, latching ms_cnt as the reaction time.
REQ-024 RUN with ms_cnt reaching TIMEOUT_MS on a tick SHALL go to SCORE with hit=0.
REQ-025 If pass and timeout occur in the same cycle, pass SHALL win.
REQ-026 pass bits other than pass[round], and any pass bit outside RUN, SHALL be ignored.
REQ-027 SCORE SHALL last one cycle with on=0.
REQ-028 In SCORE with hit=1: score SHALL increment (saturating at 15), and best_ms SHALL take the reaction time when it is strictly smaller.
REQ-029 SCORE with round=N_TESTS-1 SHALL go to DONE; otherwise round SHALL increment, ms_cnt SHALL clear, and the FSM SHALL go to GAP.
REQ-030 DONE SHALL hold round, score and best_ms stable until the next start_rise.
REQ-031 abort=1 in any state SHALL go to IDLE next cycle with on=0 and w=0; score, best_ms and round are retained.
REQ-032 abort SHALL take priority over start_rise, pass and timeout.
REQ-033 start_rise while busy SHALL be ignored.
REQ-034 on SHALL never have more than one bit set, and SHALL be all-zero outside RUN.

Reset
REQ-035 rst_n=0 SHALL immediately force IDLE, on=0, w=0, round=0, score=0, best_ms=8191, busy=0, all_done=0, ms_cnt=0, and the registered copy of start=1, so a start already high at reset release is not taken as a rising edge.
REQ-036 Reset asserted mid-test SHALL drop on within the same cycle, asynchronously.

Verification
REQ-037 N_TESTS=3, GAP_MS=2, TIMEOUT_MS=5; start_rise, then pass[0] 3 ms into RUN -> w pulse at RUN entry, on=001, score=1, best_ms=3.
REQ-038 No pass for 5 ticks in round 1 -> SCORE with hit=0, score unchanged, on goes 010 -> 000, then round=2.
REQ-039 pass[1] held during round 0, then pass[0] and the timeout tick in the same cycle -> pass[1] ignored, hit=1, reaction time=5.
REQ-040 abort during RUN of round 1 -> IDLE next cycle with on=000 and score retained; a following start_rise clears score to 0 and best_ms to 8191.
REQ-041 Complete 3 rounds with times 4, 2, 3 -> all_done=1, round=2, score=3, best_ms=2; start_rise during busy is ignored.
REQ-042 rst_n pulsed low mid-RUN with start held high -> on=0 immediately, and no session starts until start falls and rises again.

Source files
------------

// File: rtl/test_sequencer.sv
// Reaction-test session sequencer. A session steps through N_TESTS stations
// in order. Each station waits out an idle gap, is enabled and armed, and
// then either reports a pass or times out. The sequencer keeps the number of
// passes and the fastest reaction time of the session.
module test_sequencer #(
  parameter int N_TESTS    = 3,     // 1..8
  parameter int GAP_MS     = 1000,  // 1..4095
  parameter int TIMEOUT_MS = 5000   // 1..8191
) (
  input  logic               clk50M,
  input  logic               rst_n,
  input  logic               tick_1k,
  input  logic               start,
  input  logic               abort,
  input  logic [N_TESTS-1:0] pass,
  output logic [N_TESTS-1:0] on,
  output logic               w,
  output logic [2:0]         round,
  output logic [3:0]         score,
  output logic [12:0]        best_ms,
  output logic               busy,
  output logic               all_done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GAP   = 3'd1,
    S_RUN   = 3'd2,
    S_SCORE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [12:0] MS_MAX     = 13'h1FFF;  // also the "no time yet" marker
  localparam logic [12:0] GAP_LAST   = 13'(GAP_MS - 1);
  localparam logic [12:0] TIMEOUT    = 13'(TIMEOUT_MS);
  localparam logic [2:0]  LAST_ROUND = 3'(N_TESTS - 1);

  state_t               state_q, state_d;
  logic                 start_q;
  logic [12:0]          ms_cnt_q, ms_cnt_d;
  logic                 hit_q, hit_d;
  logic [12:0]          react_q, react_d;
  logic [2:0]           round_q, round_d;
  logic [3:0]           score_q, score_d;
  logic [12:0]          best_q, best_d;
  logic [N_TESTS-1:0]   on_q, on_d;
  logic                 w_q, w_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 start_rise;
  logic [12:0]          ms_inc;
  logic [12:0]          ms_now;
  logic [N_TESTS-1:0]   round_oh;
  logic                 pass_cur;

  assign start_rise = start & ~start_q;
  // Saturating millisecond counter increment.
  assign ms_inc     = (ms_cnt_q == MS_MAX) ? MS_MAX : ms_cnt_q + 13'd1;
  // Elapsed time including a tick arriving this very cycle.
  assign ms_now     = tick_1k ? ms_inc : ms_cnt_q;
  assign round_oh   = N_TESTS'(1) << round_q;
  // on_q is the one-hot of the current round while running and zero
  // otherwise, so it doubles as the mask that keeps foreign pass bits out.
  assign pass_cur   = |(pass & on_q);

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    ms_cnt_d = ms_cnt_q;
    hit_d    = hit_q;
    react_d  = react_q;
    round_d  = round_q;
    score_d  = score_q;
    best_d   = best_q;
    on_d     = on_q;
    w_d      = 1'b0;

    if (abort) begin
      // Abort wins over everything; results so far stay visible.
      state_d = S_IDLE;
      on_d    = '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_rise) begin
            state_d  = S_GAP;
            round_d  = '0;
            score_d  = '0;
            ms_cnt_d = '0;
            hit_d    = 1'b0;
            best_d   = MS_MAX;
          end
        end
        S_GAP: begin
          if (tick_1k) begin
            if (ms_cnt_q >= GAP_LAST) begin
              state_d  = S_RUN;
              ms_cnt_d = '0;
              on_d     = round_oh;
              w_d      = 1'b1;
            end else begin
              ms_cnt_d = ms_inc;
            end
          end
        end
        S_RUN: begin
          if (tick_1k) ms_cnt_d = ms_inc;
          // A pass in the same cycle as the timeout tick still counts.
          if (pass_cur) begin
            state_d = S_SCORE;
            hit_d   = 1'b1;
            react_d = ms_now;
            on_d    = '0;
          end else if (tick_1k && ms_inc >= TIMEOUT) begin
            state_d = S_SCORE;
            hit_d   = 1'b0;
            on_d    = '0;
          end
        end
        S_SCORE: begin
          if (hit_q) begin
            if (score_q != 4'hF) score_d = score_q + 4'd1;
            if (react_q < best_q) best_d = react_q;
          end
          if (round_q == LAST_ROUND) begin
            state_d = S_DONE;
          end else begin
            state_d  = S_GAP;
            round_d  = round_q + 3'd1;
            ms_cnt_d = '0;
          end
        end
        default: begin
          state_d = S_IDLE;
          on_d    = '0;
        end
      endcase
    end

    busy_d = (state_d == S_GAP) || (state_d == S_RUN) || (state_d == S_SCORE);
    done_d = (state_d == S_DONE);
  end

  // State and output registers; the start copy resets high so a start held
  // through reset is not mistaken for a fresh request.
  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      start_q  <= 1'b1;
      ms_cnt_q <= '0;
      hit_q    <= 1'b0;
      react_q  <= '0;
      round_q  <= '0;
      score_q  <= '0;
      best_q   <= MS_MAX;
      on_q     <= '0;
      w_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      start_q  <= start;
      ms_cnt_q <= ms_cnt_d;
      hit_q    <= hit_d;
      react_q  <= react_d;
      round_q  <= round_d;
      score_q  <= score_d;
      best_q   <= best_d;
      on_q     <= on_d;
      w_q      <= w_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign on       = on_q;
  assign w        = w_q;
  assign round    = round_q;
  assign score    = score_q;
  assign best_ms  = best_q;
  assign busy     = busy_q;
  assign all_done = done_q;

endmodule

// File: tb/tb_test_sequencer.sv
// Bench for test_sequencer: per-round expected results go into a scoreboard
// queue when a round's stimulus is chosen and are compared after SCORE.
module tb_test_sequencer;
  localparam int NT  = 3;
  localparam int GAP = 2;
  localparam int TMO = 5;

  logic          clk50M = 1'b0;
  logic          rst_n = 1'b0;
  logic          tick_1k = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [NT-1:0] pass = '0;
  logic [NT-1:0] on;
  logic          w;
  logic [2:0]    round;
  logic [3:0]    score;
  logic [12:0]   best_ms;
  logic          busy;
  logic          all_done;

  test_sequencer #(.N_TESTS(NT), .GAP_MS(GAP), .TIMEOUT_MS(TMO)) dut (
    .clk50M(clk50M), .rst_n(rst_n), .tick_1k(tick_1k), .start(start),
    .abort(abort), .pass(pass), .on(on), .w(w), .round(round),
    .score(score), .best_ms(best_ms), .busy(busy), .all_done(all_done)
  );

  always #10 clk50M = ~clk50M;

  typedef struct {
    int score;
    int best;
    int round;
    int done;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_score;
  int   exp_best;

  task automatic step();
    @(negedge clk50M);
  endtask

  task automatic tick();
    tick_1k = 1'b1;
    step();
    tick_1k = 1'b0;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
  endtask

  // Tick through GAP until the arm pulse appears; n = ticks used, -1 if never.
  task automatic to_run(output int n);
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (w === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  // Finish the running round: pass after t ms, pass on the timeout tick
  // (tie), or time out. Then check SCORE and the scoreboard entry.
  task automatic finish_round(input int idx, input int t, input bit hit, input bit tie);
    exp_t e;
    logic [NT-1:0] oh;
    oh = NT'(1) << idx;
    if (hit) begin
      if (exp_score < 15) exp_score++;
      if (t < exp_best) exp_best = t;
    end
    e.score = exp_score;
    e.best  = exp_best;
    e.round = (idx == NT - 1) ? idx : idx + 1;
    e.done  = (idx == NT - 1) ? 1 : 0;
    sb.push_back(e);
    if (hit && !tie) begin
      repeat (t) tick();
      pass[idx] = 1'b1;
      step();
      pass[idx] = 1'b0;
    end else begin
      repeat (TMO - 1) tick();
      n_cmp++;
      if (on !== oh) begin
        n_bad++;
        $display("FAIL pre_timeout_on r%0d: got %b want %b", idx, on, oh);
      end
      if (tie) pass[idx] = 1'b1;
      tick();
      pass[idx] = 1'b0;
    end
    n_cmp++;
    if (on !== '0) begin
      n_bad++;
      $display("FAIL score_on r%0d: got %b want 000", idx, on);
    end
    step();
    e = sb.pop_front();
    n_cmp++;
    if (score !== 4'(e.score)) begin
      n_bad++;
      $display("FAIL score r%0d: got %0d want %0d", idx, score, e.score);
    end
    n_cmp++;
    if (best_ms !== 13'(e.best)) begin
      n_bad++;
      $display("FAIL best_ms r%0d: got %0d want %0d", idx, best_ms, e.best);
    end
    n_cmp++;
    if (round !== 3'(e.round)) begin
      n_bad++;
      $display("FAIL round r%0d: got %0d want %0d", idx, round, e.round);
    end
    n_cmp++;
    if (all_done !== 1'(e.done)) begin
      n_bad++;
      $display("FAIL all_done r%0d: got %0d want %0d", idx, all_done, e.done);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) step();
    n_cmp++;
    if (on !== '0 || w !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_on_w: got on=%b w=%b want 000/0", on, w);
    end
    n_cmp++;
    if (round !== 3'd0 || score !== 4'd0) begin
      n_bad++;
      $display("FAIL reset_round_score: got %0d/%0d want 0/0", round, score);
    end
    n_cmp++;
    if (best_ms !== 13'd8191) begin
      n_bad++;
      $display("FAIL reset_best: got %0d want 8191", best_ms);
    end
    n_cmp++;
    if (busy !== 1'b0 || all_done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got busy=%b done=%b want 0/0", busy, all_done);
    end
    rst_n = 1'b1;
    repeat (2) step();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_after_reset: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_first_round();
    int n;
    exp_score = 0;
    exp_best  = 8191;
    start_pulse();
    n_cmp++;
    if (busy !== 1'b1 || round !== 3'd0 || best_ms !== 13'd8191) begin
      n_bad++;
      $display("FAIL start_session: got busy=%b round=%0d best=%0d want 1/0/8191", busy, round, best_ms);
    end
    to_run(n);
    n_cmp++;
    if (n !== GAP) begin
      n_bad++;
      $display("FAIL gap_ticks_r0: got %0d want %0d", n, GAP);
    end
    n_cmp++;
    if (on !== 3'b001) begin
      n_bad++;
      $display("FAIL run_entry_on_r0: got %b want 001", on);
    end
    step();
    n_cmp++;
    if (w !== 1'b0 || on !== 3'b001) begin
      n_bad++;
      $display("FAIL w_one_cycle: got w=%b on=%b want 0/001", w, on);
    end
    finish_round(0, 3, 1'b1, 1'b0);
  endtask

  task automatic test_timeout();
    int n;
    to_run(n);
    n_cmp++;
    if (n !== GAP || on !== 3'b010) begin
      n_bad++;
      $display("FAIL run_entry_r1: got ticks=%0d on=%b want %0d/010", n, on, GAP);
    end
    finish_round(1, TMO, 1'b0, 1'b0);
  endtask

  task automatic test_tie();
    int n;
    to_run(n);
    finish_round(2, 4, 1'b1, 1'b0);
    exp_score = 0;
    exp_best  = 8191;
    pass[1] = 1'b1;
    start_pulse();
    to_run(n);
    n_cmp++;
    if (n !== GAP || on !== 3'b001) begin
      n_bad++;
      $display("FAIL tie_entry: got ticks=%0d on=%b want %0d/001", n, on, GAP);
    end
    finish_round(0, TMO, 1'b1, 1'b1);
    pass[1] = 1'b0;
  endtask

  task automatic test_abort();
    int n;
    to_run(n);
    n_cmp++;
    if (on !== 3'b010) begin
      n_bad++;
      $display("FAIL abort_pre_on: got %b want 010", on);
    end
    tick();
    abort   = 1'b1;
    pass[1] = 1'b1;
    step();
    abort   = 1'b0;
    pass[1] = 1'b0;
    n_cmp++;
    if (on !== '0 || w !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_idle: got on=%b w=%b busy=%b want 000/0/0", on, w, busy);
    end
    n_cmp++;
    if (score !== 4'd1 || best_ms !== 13'd5 || round !== 3'd1) begin
      n_bad++;
      $display("FAIL abort_retain: got %0d/%0d/%0d want 1/5/1", score, best_ms, round);
    end
    repeat (2) tick();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_stays_idle: got busy=%b want 0", busy);
    end
    exp_score = 0;
    exp_best  = 8191;
    start_pulse();
    n_cmp++;
    if (score !== 4'd0 || best_ms !== 13'd8191 || round !== 3'd0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL restart_clear: got %0d/%0d/%0d busy=%b want 0/8191/0/1", score, best_ms, round, busy);
    end
  endtask

  task automatic test_full_session();
    int n;
    to_run(n);
    finish_round(0, 4, 1'b1, 1'b0);
    to_run(n);
    start_pulse();
    n_cmp++;
    if (busy !== 1'b1 || round !== 3'd1 || on !== 3'b010 || score !== 4'd1) begin
      n_bad++;
      $display("FAIL start_while_busy: got busy=%b round=%0d on=%b score=%0d want 1/1/010/1", busy, round, on, score);
    end
    finish_round(1, 2, 1'b1, 1'b0);
    to_run(n);
    finish_round(2, 3, 1'b1, 1'b0);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL done_busy: got %b want 0", busy);
    end
    pass = '1;
    repeat (3) tick();
    pass = '0;
    step();
    n_cmp++;
    if (round !== 3'd2 || score !== 4'd3 || best_ms !== 13'd2 || all_done !== 1'b1) begin
      n_bad++;
      $display("FAIL done_hold: got %0d/%0d/%0d done=%b want 2/3/2/1", round, score, best_ms, all_done);
    end
  endtask

  task automatic test_reset_mid_run();
    int n;
    start_pulse();
    to_run(n);
    n_cmp++;
    if (on !== 3'b001) begin
      n_bad++;
      $display("FAIL rst_pre_on: got %b want 001", on);
    end
    start = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (on !== '0) begin
      n_bad++;
      $display("FAIL rst_async_on: got %b want 000", on);
    end
    step();
    rst_n = 1'b1;
    repeat (4) step();
    n_cmp++;
    if (busy !== 1'b0 || on !== '0) begin
      n_bad++;
      $display("FAIL rst_start_held: got busy=%b on=%b want 0/000", busy, on);
    end
    start = 1'b0;
    step();
    start = 1'b1;
    step();
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_new_rise: got busy=%b want 1", busy);
    end
    start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_round();
    test_timeout();
    test_tie();
    test_abort();
    test_full_session();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
